// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone interconnect arbiters.
// Holds the FSM encoding and a fixed-size round-robin pick function.
package wb_arb_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_e;

  localparam int ARB_NUM_M = 8;
  localparam int ARB_PRI_W = 2;
  localparam int IDX_W     = $clog2(ARB_NUM_M);

  // Returns {found, idx}: highest priority wins, ties go to the
  // first requester after ptr in cyclic order.
  function automatic logic [IDX_W:0] rr_pick(
    input logic [ARB_NUM_M-1:0]           req,
    input logic [ARB_NUM_M*ARB_PRI_W-1:0] pri,
    input logic [IDX_W-1:0]               ptr
  );
    logic [ARB_PRI_W-1:0] maxp;
    logic [IDX_W-1:0]     idx;
    logic                 found;
    int                   j;
    maxp  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < ARB_NUM_M; i++) begin
      if (req[i] && pri[i*ARB_PRI_W +: ARB_PRI_W] > maxp)
        maxp = pri[i*ARB_PRI_W +: ARB_PRI_W];
    end
    for (int k = 1; k <= ARB_NUM_M; k++) begin
      j = (int'(ptr) + k) % ARB_NUM_M;
      if (!found && req[j] &&
          pri[j*ARB_PRI_W +: ARB_PRI_W] == maxp) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational priority-then-round-robin selector.
// Kept apart from the FSM so selection can be tested on its own.
module wb_arb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NUM_M = 8,
  parameter int PRI_W = 2,
  parameter int IW    = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0]       req,
  input  logic [NUM_M*PRI_W-1:0] pri,
  input  logic [IW-1:0]          ptr,
  output logic [IW-1:0]          idx,
  output logic                   found
);

  logic [PRI_W-1:0] maxp;

  // Find top priority among requesters, then scan from ptr+1.
  always_comb begin
    maxp  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (req[i] && pri[i*PRI_W +: PRI_W] > maxp)
        maxp = pri[i*PRI_W +: PRI_W];
    end
    for (int k = 1; k <= NUM_M; k++) begin
      if (!found &&
          req[(int'(ptr) + k) % NUM_M] &&
          pri[((int'(ptr) + k) % NUM_M)*PRI_W +: PRI_W]
            == maxp) begin
        found = 1'b1;
        idx   = IW'((int'(ptr) + k) % NUM_M);
      end
    end
  end

endmodule

// File: rtl/wb_slave_arbiter.sv
// Per-slave-port arbiter: holds a grant for the whole bus cycle
// and releases it on CYC drop or a watchdog timeout.
module wb_slave_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_M     = 8,
  parameter int PRI_W     = 2,
  parameter int TO_CYCLES = 256,
  parameter int TO_W      = 9,
  localparam int IW       = $clog2(NUM_M)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_M-1:0]       m_cyc,
  input  logic [NUM_M*PRI_W-1:0] m_pri,
  input  logic                   s_ack,
  input  logic                   s_err,
  input  logic                   s_rty,
  output logic [NUM_M-1:0]       gnt,
  output logic [IW-1:0]          gnt_idx,
  output logic                   gnt_vld,
  output logic                   to_err,
  output logic [IW-1:0]          to_idx
);

  arb_state_e       state_q, state_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             vld_q, vld_d;
  logic             toe_q, toe_d;
  logic [IW-1:0]    toi_q, toi_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic [NUM_M-1:0] blk_q, blk_d;

  logic [NUM_M-1:0] req;
  logic [IW-1:0]    win_idx;
  logic             win_found;
  logic             term;

  assign req  = m_cyc & ~blk_q;
  assign term = s_ack | s_err | s_rty;

  wb_arb_rr_pick #(
    .NUM_M (NUM_M),
    .PRI_W (PRI_W),
    .IW    (IW)
  ) u_pick (
    .req   (req),
    .pri   (m_pri),
    .ptr   (ptr_q),
    .idx   (win_idx),
    .found (win_found)
  );

  // Next-state: grant in IDLE, hold/release and watchdog in GRANT.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    toe_d   = 1'b0;
    toi_d   = toi_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q & m_cyc;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d   = '0;
          gnt_d[win_idx] = 1'b1;
          idx_d   = win_idx;
          vld_d   = 1'b1;
          ptr_d   = win_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!m_cyc[idx_q]) begin
          gnt_d   = '0;
          vld_d   = 1'b0;
          state_d = IDLE;
        end else if (term) begin
          cnt_d = '0;
        end else if (cnt_q == TO_W'(TO_CYCLES-1)) begin
          gnt_d        = '0;
          vld_d        = 1'b0;
          toe_d        = 1'b1;
          toi_d        = idx_q;
          blk_d[idx_q] = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      toe_q   <= 1'b0;
      toi_q   <= '0;
      ptr_q   <= IW'(NUM_M-1);
      cnt_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      toe_q   <= toe_d;
      toi_q   <= toi_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;
  assign to_err  = toe_q;
  assign to_idx  = toi_q;

endmodule
